// File: rtl/mem_resp_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_wb_stage
// Purpose  : MEM->WB pipeline register. Owns the data-memory transaction,
//            stalls upstream until the response arrives, aligns and extends
//            load data, and presents the register-file write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp_wb_stage #(
    parameter int unsigned RESP_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_addr,
    input  logic [3:0]  in_rmask,
    input  logic [3:0]  in_wmask,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd_s,
    input  logic        in_regf_we,
    input  logic [31:0] in_result,
    output logic        stall,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd_s,
    output logic [31:0] wb_data,
    output logic        wb_trap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Last WAIT-cycle count value on which a silent memory is given up on.
    localparam logic [31:0] c_timeout_last = RESP_TIMEOUT - 1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;

    logic        r_valid;
    logic [31:0] r_addr;
    logic [3:0]  r_rmask;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd_s;
    logic        r_regf_we;
    logic [31:0] r_result;
    logic        r_misalign;

    logic        w_in_mem;
    logic        w_in_misalign;
    logic        w_in_go;
    logic        w_done;
    logic        w_timeout;
    logic        w_stall;
    logic        w_trap;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_in_mem      = (|in_rmask) || (|in_wmask);
    assign w_in_misalign = w_in_mem &&
                           ((in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                            (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00));
    assign w_in_go       = in_valid && w_in_mem && !w_in_misalign;

    always_comb begin
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        dmem_addr   = 32'h0;
        dmem_rmask  = 4'h0;
        dmem_wmask  = 4'h0;
        dmem_wdata  = 32'h0;
        case (r_state)
            ST_IDLE: w_done = r_valid;
            ST_REQ: begin
                dmem_addr  = {r_addr[31:2], 2'b00};
                dmem_rmask = r_rmask;
                dmem_wmask = r_wmask;
                dmem_wdata = r_wdata;
                w_done     = dmem_resp;
            end
            ST_WAIT: begin
                // A real response wins over a timeout landing on the same cycle.
                if (dmem_resp) begin
                    w_done = 1'b1;
                end else if (RESP_TIMEOUT != 0 && r_cnt == c_timeout_last) begin
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                end
            end
            default: w_done = 1'b0;
        endcase
    end

    assign w_stall = (r_state != ST_IDLE) && !w_done;

    always_comb begin
        w_state_nxt = r_state;
        if (!w_stall) begin
            w_state_nxt = w_in_go ? ST_REQ : ST_IDLE;
        end else if (r_state == ST_REQ) begin
            w_state_nxt = ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 32'h0;
            r_valid    <= 1'b0;
            r_addr     <= 32'h0;
            r_rmask    <= 4'h0;
            r_wmask    <= 4'h0;
            r_wdata    <= 32'h0;
            r_funct3   <= 3'h0;
            r_rd_s     <= 5'h0;
            r_regf_we  <= 1'b0;
            r_result   <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_WAIT && w_stall) ? r_cnt + 32'd1 : 32'h0;
            if (!w_stall) begin
                r_valid    <= in_valid;
                r_addr     <= in_addr;
                r_rmask    <= in_rmask;
                r_wmask    <= in_wmask;
                r_wdata    <= in_wdata;
                r_funct3   <= in_funct3;
                r_rd_s     <= in_rd_s;
                r_regf_we  <= in_regf_we;
                r_result   <= in_result;
                r_misalign <= w_in_misalign;
            end
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    assign w_trap   = r_misalign || w_timeout;
    assign stall    = w_stall;
    assign wb_valid = w_done;
    assign wb_trap  = w_done && w_trap;
    assign wb_we    = w_done && r_regf_we && (r_rd_s != 5'd0) && !w_trap && (r_wmask == 4'h0);
    assign wb_rd_s  = w_done ? r_rd_s : 5'd0;
    assign wb_data  = !w_done ? 32'h0 : ((|r_rmask) ? w_load : r_result);

endmodule
`default_nettype wire
